// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, redirect capture and
// fetch-decode latch control for an in-order pipeline.

package fetch_unit_pkg;
  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    STALL  = 2'd1,
    FLUSH  = 2'd2
  } pipe_state_t;
endpackage

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] iload,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] f_instr,
  output logic [31:0] f_pc4,
  output pipe_state_t fd_state
);

  typedef enum logic [1:0] {
    S_FETCH      = 2'd0,
    S_REDIR_WAIT = 2'd1,
    S_HALTED     = 2'd2
  } fetch_state_t;

  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  fetch_state_t state_q, state_d;
  pipe_state_t  fd_state_d;
  logic [31:0]  redir_aligned;

  // Targets are always word aligned; drop the two low bits on capture.
  assign redir_aligned = redirect_pc & 32'hFFFF_FFFC;

  // Memory request and latch data are straight from the current PC / response.
  assign imemaddr = pc_q;
  assign f_instr  = iload;
  assign f_pc4    = pc_q + 32'd4;
  assign imemREN  = (!RST) && (state_q != S_HALTED);
  assign fd_state = RST ? FLUSH : fd_state_d;

  // Per-cycle decision: latch control and next PC/pending/state.
  always_comb begin
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    state_d    = state_q;
    fd_state_d = FLUSH;
    case (state_q)
      S_FETCH: begin
        if (halt) begin
          fd_state_d = FLUSH;
          state_d    = S_HALTED;
        end else if (redirect) begin
          fd_state_d = FLUSH;
          if (ihit) begin
            pc_d = redir_aligned;
          end else begin
            pend_pc_d = redir_aligned;
            state_d   = S_REDIR_WAIT;
          end
        end else if (stall) begin
          // Hold the latch and the PC; a returned word is simply refetched.
          fd_state_d = STALL;
        end else if (ihit) begin
          fd_state_d = NORMAL;
          pc_d       = pc_q + 32'd4;
        end else begin
          fd_state_d = FLUSH;
        end
      end
      S_REDIR_WAIT: begin
        // The old request is still outstanding; its data is thrown away.
        fd_state_d = FLUSH;
        if (halt) begin
          state_d = S_HALTED;
        end else begin
          if (redirect) begin
            pend_pc_d = redir_aligned;
          end else begin
            pend_pc_d = pend_pc_q;
          end
          if (ihit) begin
            pc_d    = redirect ? redir_aligned : pend_pc_q;
            state_d = S_FETCH;
          end else begin
            pc_d = pc_q;
          end
        end
      end
      S_HALTED: begin
        fd_state_d = STALL;
      end
      default: begin
        fd_state_d = FLUSH;
        state_d    = S_FETCH;
      end
    endcase
  end

  // State registers; reset abandons any request or pending redirect at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q      <= PC_INIT;
      pend_pc_q <= 32'h0000_0000;
      state_q   <= S_FETCH;
    end else begin
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      state_q   <= state_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a reference model pushes the expected
// outputs of each cycle into a scoreboard, popped and compared mid-cycle.

module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] PC_INIT = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ihit = 1'b0;
  logic [31:0] iload = 32'h0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt = 1'b0;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] f_instr;
  logic [31:0] f_pc4;
  pipe_state_t fd_state;

  typedef struct packed {
    logic        ren;
    logic [31:0] addr;
    logic [1:0]  fd;
    logic [31:0] pc4;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  // Reference model state: 0 = FETCH, 1 = REDIR_WAIT, 2 = HALTED
  logic [31:0] m_pc = PC_INIT;
  logic [31:0] m_pend = 32'h0;
  int          m_st = 0;

  fetch_unit #(.PC_INIT(PC_INIT)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .iload(iload), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .imemREN(imemREN), .imemaddr(imemaddr), .f_instr(f_instr),
    .f_pc4(f_pc4), .fd_state(fd_state)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, predict outputs, compare at negedge, advance model.
  task automatic step(input logic rst_v, input logic h, input logic [31:0] ld,
                      input logic s, input logic r, input logic [31:0] rp, input logic ht);
    exp_t e, g;
    logic [31:0] rpa, n_pc, n_pend;
    int n_st;
    RST = rst_v; ihit = h; iload = ld; stall = s;
    redirect = r; redirect_pc = rp; halt = ht;
    if (rst_v) begin
      m_pc = PC_INIT; m_pend = 32'h0; m_st = 0;
    end
    rpa = {rp[31:2], 2'b00};
    e.ren = (!rst_v) && (m_st != 2);
    e.addr = m_pc;
    e.pc4 = m_pc + 32'd4;
    e.instr = ld;
    e.fd = FLUSH;
    n_pc = m_pc; n_pend = m_pend; n_st = m_st;
    if (rst_v) begin
      e.fd = FLUSH;
    end else if (m_st == 0) begin
      if (ht) begin
        n_st = 2;
      end else if (r) begin
        if (h) n_pc = rpa;
        else begin n_pend = rpa; n_st = 1; end
      end else if (s) begin
        e.fd = STALL;
      end else if (h) begin
        e.fd = NORMAL; n_pc = m_pc + 32'd4;
      end
    end else if (m_st == 1) begin
      if (ht) n_st = 2;
      else begin
        if (r) n_pend = rpa;
        if (h) begin n_pc = r ? rpa : m_pend; n_st = 0; end
      end
    end else begin
      e.fd = STALL;
    end
    sb.push_back(e);
    @(negedge CLK);
    g = sb.pop_front();
    check_val("imemREN", {31'd0, imemREN}, {31'd0, g.ren});
    check_val("imemaddr", imemaddr, g.addr);
    check_val("fd_state", {30'd0, fd_state}, {30'd0, g.fd});
    check_val("f_pc4", f_pc4, g.pc4);
    check_val("f_instr", f_instr, g.instr);
    @(posedge CLK);
    m_pc = n_pc; m_pend = n_pend; m_st = n_st;
    #1;
  endtask

  localparam logic [31:0] LW = 32'h2001_0001;

  initial begin
    @(posedge CLK); #1;
    // Reset held, then fetch sequentially from PC_INIT
    step(1'b1, 1'b1, LW, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, LW, 1'b0, 1'b0, 32'h0, 1'b0);
    check_val("rst_addr", imemaddr, PC_INIT);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, LW, 1'b0, 1'b0, 32'h0, 1'b0);
    check_val("addr_10", imemaddr, 32'h10);
    // Miss for three cycles at 0x10
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, LW, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, LW, 1'b0, 1'b0, 32'h0, 1'b0);
    check_val("addr_14", imemaddr, 32'h14);
    // Run to 0x40 then two redirects while the request is outstanding
    for (int i = 0; i < 11; i++) step(1'b0, 1'b1, LW, 1'b0, 1'b0, 32'h0, 1'b0);
    check_val("addr_40", imemaddr, 32'h40);
    step(1'b0, 1'b0, LW, 1'b0, 1'b1, 32'h200, 1'b0);
    step(1'b0, 1'b0, LW, 1'b0, 1'b1, 32'h300, 1'b0);
    step(1'b0, 1'b0, LW, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, LW, 1'b0, 1'b0, 32'h0, 1'b0);
    check_val("addr_300", imemaddr, 32'h300);
    // Stall handling at 0x8
    step(1'b1, 1'b0, LW, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, LW, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, LW, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, LW, 1'b1, 1'b0, 32'h0, 1'b0);
    check_val("stall_pc8", imemaddr, 32'h8);
    step(1'b0, 1'b1, LW, 1'b1, 1'b1, 32'h80, 1'b0);
    check_val("addr_80", imemaddr, 32'h80);
    // Wrap and alignment
    step(1'b0, 1'b1, LW, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    check_val("pc4_wrap", f_pc4, 32'h0);
    step(1'b0, 1'b1, LW, 1'b0, 1'b0, 32'h0, 1'b0);
    check_val("addr_wrap", imemaddr, 32'h0);
    step(1'b0, 1'b1, LW, 1'b0, 1'b1, 32'h103, 1'b0);
    check_val("addr_align", imemaddr, 32'h100);
    // Halt at 0x24, inputs ignored, then reset resumes
    step(1'b0, 1'b1, LW, 1'b0, 1'b1, 32'h24, 1'b0);
    step(1'b0, 1'b1, LW, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, LW, 1'b1, 1'b1, 32'h500, 1'b0);
    check_val("halt_pc", imemaddr, 32'h24);
    step(1'b1, 1'b0, LW, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, LW, 1'b0, 1'b0, 32'h0, 1'b0);
    check_val("resume", imemaddr, PC_INIT + 32'd4);
    // Halt while a redirect is pending, then reset mid-wait
    step(1'b0, 1'b0, LW, 1'b0, 1'b1, 32'h600, 1'b0);
    step(1'b0, 1'b1, LW, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, LW, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, LW, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, LW, 1'b0, 1'b1, 32'h700, 1'b0);
    step(1'b1, 1'b1, LW, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, LW, 1'b0, 1'b0, 32'h0, 1'b0);
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 40) == 0) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 1)), $urandom,
           ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 6) == 0) ? 1'b1 : 1'b0,
           $urandom,
           ($urandom_range(0, 60) == 0) ? 1'b1 : 1'b0);
    end
    if (sb.size() != 0) check_val("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_INIT, default 32'h00000000, meaning the PC value loaded on reset.
REQ-002 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port ihit  input  1  instruction memory response valid for the current imemaddr.
REQ-005 SHALL have port iload  input  32  instruction word returned with ihit.
REQ-006 SHALL have port stall  input  1  hazard unit holds the fetch-decode latch.
REQ-007 SHALL have port redirect  input  1  branch/jump resolved taken; fetch from redirect_pc.
REQ-008 SHALL have port redirect_pc  input  32  redirect target address.
REQ-009 SHALL have port halt  input  1  halt instruction retired; stop fetching.
REQ-010 SHALL have port imemREN  output  1  instruction memory read enable.
REQ-011 SHALL have port imemaddr  output  32  instruction memory address.
REQ-012 SHALL have port f_instr  output  32  instruction presented to the fetch-decode latch.
REQ-013 SHALL have port f_pc4  output  32  PC+4 of f_instr, presented to the latch.
REQ-014 SHALL have port fd_state  output  pipe_state_t  latch control: NORMAL (load), STALL (hold), FLUSH (load bubble).

Function
REQ-015 SHALL hold registers pc (32), pend_pc (32), state in {FETCH, REDIR_WAIT, HALTED}.
REQ-016 SHALL drive imemaddr = pc and imemREN = 1 in FETCH and REDIR_WAIT; imemREN = 0 in HALTED.
REQ-017 SHALL keep imemaddr stable from request start until ihit; pc changes only on a cycle with ihit or on halt.
REQ-018 SHALL drive f_instr = iload and f_pc4 = pc + 4 combinationally, zero latency; pc + 4 wraps modulo 2^32.
REQ-019 SHALL force redirect_pc[1:0] to 2'b00 when captured.
REQ-020 SHALL apply per-cycle priority in FETCH: halt > redirect > stall > ihit.
REQ-021 FETCH, halt: fd_state = FLUSH; next state HALTED.
REQ-022 FETCH, redirect and ihit: fd_state = FLUSH; pc <= redirect_pc; stay FETCH.
REQ-023 FETCH, redirect, no ihit: fd_state = FLUSH; pend_pc <= redirect_pc; next state REDIR_WAIT.
REQ-024 FETCH, stall (no redirect): fd_state = STALL; pc holds regardless of ihit.
REQ-025 FETCH, ihit only: fd_state = NORMAL; pc <= pc + 4.
REQ-026 FETCH, none of the above: fd_state = FLUSH (bubble into decode).
REQ-027 REDIR_WAIT: fd_state = FLUSH every cycle; returned iload discarded; new redirect overwrites pend_pc (latest wins); stall ignored.
REQ-028 REDIR_WAIT with ihit: pc <= pend_pc (or redirect_pc if redirect same cycle); next state FETCH.
REQ-029 REDIR_WAIT with halt: next state HALTED, pending redirect dropped.
REQ-030 HALTED: fd_state = STALL; pc frozen; all inputs ignored until reset.

Reset
REQ-031 SHALL, while RST = 1, set pc = PC_INIT, pend_pc = 0, state = FETCH, and force imemREN = 0, fd_state = FLUSH.
REQ-032 SHALL, with RST = 1, drive imemaddr = PC_INIT, f_pc4 = PC_INIT + 4; f_instr follows iload.
REQ-033 SHALL, on RST assertion mid-operation (any state), abandon any outstanding request and pending redirect immediately.
REQ-034 SHALL begin fetching PC_INIT on the first cycle after RST deasserts.

Verification
REQ-035 Reset release, ihit every cycle, iload = 32'h20010001 -> imemaddr 0,4,8,...; fd_state NORMAL; f_pc4 = imemaddr + 4.
REQ-036 ihit low 3 cycles at pc 32'h10 -> imemaddr held 32'h10, fd_state FLUSH x3; then ihit -> NORMAL, next addr 32'h14.
REQ-037 redirect to 32'h200 while ihit low at pc 32'h40, second redirect to 32'h300 next cycle, ihit 2 cycles later -> addr held 32'h40, FLUSH throughout, next addr 32'h300.
REQ-038 stall and ihit together at pc 32'h8 -> fd_state STALL, pc stays 32'h8; stall and redirect to 32'h80 same cycle -> FLUSH, next addr 32'h80.
REQ-039 pc = 32'hFFFFFFFC with ihit -> f_pc4 = 0, next imemaddr 32'h0; redirect_pc = 32'h103 -> next addr 32'h100.
REQ-040 halt at pc 32'h24 -> next cycle imemREN = 0, fd_state STALL, pc frozen at 32'h24; RST pulse -> imemaddr = PC_INIT, fetching resumes.
